// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage RV32I core.
//
// Tracks register-use information for the instructions in E, M and W in a
// private shadow pipeline and derives from it, each cycle:
//   * the E-stage operand forwarding selects (00 regfile, 01 W result,
//     10 M-stage ALU result),
//   * the load-use stall (hold PC and IF/ID, bubble ID/EX),
//   * the taken-branch flush (clear IF/ID and ID/EX),
//   * the data-memory freeze (hold everything downstream of IF/ID).
// Stall and flush cycles are counted for debug.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   valid_d, rs1_d, rs2_d, rd_d,  D-stage instruction register usage
//   reg_write_d, result_src_d
//   pc_src_e                      taken branch/jump resolved in E
//   dmem_wait                     data memory not ready
//   fwd_a_e, fwd_b_e              forwarding mux selects for E operands
//   stall_f, stall_d              hold PC / IF/ID
//   flush_d, flush_e              clear IF/ID / ID/EX
//   freeze                        hold ID/EX, EX/MEM, MEM/WB
//   stall_cnt, flush_cnt          load-use stall / branch flush cycle counts
module hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_d,
  input  logic [RA_W-1:0]  rs1_d,
  input  logic [RA_W-1:0]  rs2_d,
  input  logic [RA_W-1:0]  rd_d,
  input  logic             reg_write_d,
  input  logic [1:0]       result_src_d,
  input  logic             pc_src_e,
  input  logic             dmem_wait,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  // E-stage shadow
  logic            vld_e_q, vld_e_d;
  logic [RA_W-1:0] rs1_e_q, rs1_e_d;
  logic [RA_W-1:0] rs2_e_q, rs2_e_d;
  logic [RA_W-1:0] rd_e_q,  rd_e_d;
  logic            rw_e_q,  rw_e_d;
  logic [1:0]      src_e_q, src_e_d;
  // M-stage shadow
  logic            vld_m_q, vld_m_d;
  logic [RA_W-1:0] rd_m_q,  rd_m_d;
  logic            rw_m_q,  rw_m_d;
  logic [1:0]      src_m_q, src_m_d;
  // W-stage shadow
  logic            vld_w_q, vld_w_d;
  logic [RA_W-1:0] rd_w_q,  rd_w_d;
  logic            rw_w_q,  rw_w_d;
  // debug counters
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [1:0] src_in;
  logic       late_e;
  logic       lu;
  logic       br;

  // M has priority over W (it is the younger value); x0 is never forwarded
  // and only an ALU result is available in M.
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] rs,
    input logic            vm,
    input logic            rwm,
    input logic [RA_W-1:0] rdm,
    input logic [1:0]      srcm,
    input logic            vw,
    input logic            rww,
    input logic [RA_W-1:0] rdw
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (vm && rwm && (rdm == rs) && (srcm == SRC_ALU)) begin
        sel = 2'b10;
      end else if (vw && rww && (rdw == rs)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  // The reserved encoding behaves as an ALU result everywhere downstream.
  assign src_in = (result_src_d == 2'b11) ? SRC_ALU : result_src_d;

  // A result not available until M/W completes (load data, PC+4 is routed
  // through the W mux only) cannot feed the next instruction from M.
  assign late_e = vld_e_q && rw_e_q && (rd_e_q != '0) &&
                  ((src_e_q == SRC_LOAD) || (src_e_q == SRC_PC4));
  assign lu     = late_e && valid_d && ((rs1_d == rd_e_q) || (rs2_d == rd_e_q));
  assign br     = pc_src_e;

  always_comb begin
    fwd_a_e = fwd_sel(rs1_e_q, vld_m_q, rw_m_q, rd_m_q, src_m_q,
                      vld_w_q, rw_w_q, rd_w_q);
    fwd_b_e = fwd_sel(rs2_e_q, vld_m_q, rw_m_q, rd_m_q, src_m_q,
                      vld_w_q, rw_w_q, rd_w_q);
    stall_f = lu && !br;
    stall_d = lu && !br;
    flush_d = br;
    flush_e = br || lu;
    freeze  = 1'b0;
    if (rst) begin
      fwd_a_e = 2'b00;
      fwd_b_e = 2'b00;
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (dmem_wait) begin
      // Nothing may move or be cleared while memory is busy; any pending
      // branch or load-use resolves once the wait drops.
      freeze  = 1'b1;
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_d = 1'b0;
      flush_e = 1'b0;
    end
  end

  always_comb begin
    vld_e_d     = vld_e_q;
    rs1_e_d     = rs1_e_q;
    rs2_e_d     = rs2_e_q;
    rd_e_d      = rd_e_q;
    rw_e_d      = rw_e_q;
    src_e_d     = src_e_q;
    vld_m_d     = vld_m_q;
    rd_m_d      = rd_m_q;
    rw_m_d      = rw_m_q;
    src_m_d     = src_m_q;
    vld_w_d     = vld_w_q;
    rd_w_d      = rd_w_q;
    rw_w_d      = rw_w_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rst) begin
      vld_e_d     = 1'b0;
      rs1_e_d     = '0;
      rs2_e_d     = '0;
      rd_e_d      = '0;
      rw_e_d      = 1'b0;
      src_e_d     = 2'b00;
      vld_m_d     = 1'b0;
      rd_m_d      = '0;
      rw_m_d      = 1'b0;
      src_m_d     = 2'b00;
      vld_w_d     = 1'b0;
      rd_w_d      = '0;
      rw_w_d      = 1'b0;
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else if (!dmem_wait) begin
      vld_w_d = vld_m_q;
      rd_w_d  = rd_m_q;
      rw_w_d  = rw_m_q;
      vld_m_d = vld_e_q;
      rd_m_d  = rd_e_q;
      rw_m_d  = rw_e_q;
      src_m_d = src_e_q;
      if (br || lu) begin
        // bubble: fully cleared so it can never match a source register
        vld_e_d = 1'b0;
        rs1_e_d = '0;
        rs2_e_d = '0;
        rd_e_d  = '0;
        rw_e_d  = 1'b0;
        src_e_d = 2'b00;
      end else begin
        vld_e_d = valid_d;
        rs1_e_d = rs1_d;
        rs2_e_d = rs2_d;
        rd_e_d  = rd_d;
        rw_e_d  = reg_write_d;
        src_e_d = src_in;
      end
      if (br) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if (lu) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    vld_e_q     <= vld_e_d;
    rs1_e_q     <= rs1_e_d;
    rs2_e_q     <= rs2_e_d;
    rd_e_q      <= rd_e_d;
    rw_e_q      <= rw_e_d;
    src_e_q     <= src_e_d;
    vld_m_q     <= vld_m_d;
    rd_m_q      <= rd_m_d;
    rw_m_q      <= rw_m_d;
    src_m_q     <= src_m_d;
    vld_w_q     <= vld_w_d;
    rd_w_q      <= rd_w_d;
    rw_w_q      <= rw_w_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Each step drives one D-stage
// instruction (plus branch/wait inputs) and pushes the expected outputs for
// that cycle; a monitor pops and compares them on the falling edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        reg_write_d;
  logic [1:0]  result_src_d;
  logic        pc_src_e;
  logic        dmem_wait;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        stall_f, stall_d, flush_d, flush_e, freeze;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [1:0]  fa, fb;
    logic        sf, sd, fd, fe, fz;
    logic [31:0] sc, fc;
  } exp_t;

  exp_t sb[$];
  int   exp_sc = 0;
  int   exp_fc = 0;

  hazard_ctrl #(.RA_W(5), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_d      (valid_d),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rd_d         (rd_d),
    .reg_write_d  (reg_write_d),
    .result_src_d (result_src_d),
    .pc_src_e     (pc_src_e),
    .dmem_wait    (dmem_wait),
    .fwd_a_e      (fwd_a_e),
    .fwd_b_e      (fwd_b_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .freeze       (freeze),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".fwd_a"},     32'(fwd_a_e),   32'(e.fa));
      chk({e.tag, ".fwd_b"},     32'(fwd_b_e),   32'(e.fb));
      chk({e.tag, ".stall_f"},   32'(stall_f),   32'(e.sf));
      chk({e.tag, ".stall_d"},   32'(stall_d),   32'(e.sd));
      chk({e.tag, ".flush_d"},   32'(flush_d),   32'(e.fd));
      chk({e.tag, ".flush_e"},   32'(flush_e),   32'(e.fe));
      chk({e.tag, ".freeze"},    32'(freeze),    32'(e.fz));
      chk({e.tag, ".stall_cnt"}, stall_cnt,      e.sc);
      chk({e.tag, ".flush_cnt"}, flush_cnt,      e.fc);
    end
  end

  // One cycle: drive D-stage inputs, queue the expected outputs, advance.
  // is/ifl say whether this cycle should bump the stall/flush counter.
  task automatic cyc(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic rw, input logic [1:0] src,
                     input logic pc, input logic dw, input string tag,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input logic sf, input logic sd, input logic fd,
                     input logic fe, input logic fz, input logic is, input logic ifl);
    exp_t e;
    valid_d      = v;
    rs1_d        = r1;
    rs2_d        = r2;
    rd_d         = rd;
    reg_write_d  = rw;
    result_src_d = src;
    pc_src_e     = pc;
    dmem_wait    = dw;
    e.tag = tag; e.fa = fa; e.fb = fb;
    e.sf = sf; e.sd = sd; e.fd = fd; e.fe = fe; e.fz = fz;
    e.sc = 32'(exp_sc); e.fc = 32'(exp_fc);
    sb.push_back(e);
    if (is)  exp_sc++;
    if (ifl) exp_fc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    valid_d = 1'b0; rs1_d = '0; rs2_d = '0; rd_d = '0;
    reg_write_d = 1'b0; result_src_d = 2'b00; pc_src_e = 1'b0; dmem_wait = 1'b0;
    @(posedge clk);
    #1;

    // reset held with random inputs
    for (int i = 0; i < 2; i++) begin
      valid_d      = 1'($urandom);
      rs1_d        = 5'($urandom);
      rs2_d        = 5'($urandom);
      rd_d         = 5'($urandom);
      reg_write_d  = 1'($urandom);
      result_src_d = 2'($urandom);
      pc_src_e     = 1'($urandom);
      dmem_wait    = 1'($urandom);
      e.tag = "reset"; e.fa = 2'b00; e.fb = 2'b00;
      e.sf = 1'b0; e.sd = 1'b0; e.fd = 1'b1; e.fe = 1'b1; e.fz = 1'b0;
      e.sc = 32'd0; e.fc = 32'd0;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    //   v  rs1 rs2 rd rw src pc dw  tag              fa fb sf sd fd fe fz is if
    // ALU->ALU back to back: forward from M
    cyc(1, 1, 2, 5, 1, 0, 0, 0, "alu_add5",        0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 5, 1, 6, 1, 0, 0, 0, "alu_sub_issue",   0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, "alu_fwd_m",       2, 0, 0, 0, 0, 0, 0, 0, 0);
    // one nop between: forward from W
    cyc(1, 1, 2, 5, 1, 0, 0, 0, "gap_add5",        0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, "gap_nop",         0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 5, 1, 6, 1, 0, 0, 0, "gap_sub_issue",   0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, "gap_fwd_w",       1, 0, 0, 0, 0, 0, 0, 0, 0);
    // writer to x0: nothing forwarded
    cyc(1, 1, 2, 0, 1, 0, 0, 0, "x0_add",          0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 6, 1, 0, 0, 0, "x0_sub_issue",    0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, "x0_no_fwd",       0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use: one stall cycle, then forward from W
    cyc(1, 1, 0, 7, 1, 1, 0, 0, "lu_load",         0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 7, 7, 8, 1, 0, 0, 0, "lu_stall",        0, 0, 1, 1, 0, 1, 0, 1, 0);
    cyc(1, 7, 7, 8, 1, 0, 0, 0, "lu_bubble",       0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, "lu_fwd_w",        1, 1, 0, 0, 0, 0, 0, 0, 0);
    // x3 written in both M and W: M wins
    cyc(1, 1, 2, 3, 1, 0, 0, 0, "dbl_add3a",       0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 2, 3, 1, 0, 0, 0, "dbl_add3b",       0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 3, 4, 10, 1, 0, 0, 0, "dbl_use_issue",  0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, "dbl_m_wins",      2, 0, 0, 0, 0, 0, 0, 0, 0);
    // branch and load-use together: branch wins
    cyc(1, 1, 0, 7, 1, 1, 0, 0, "br_load",         0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 7, 7, 8, 1, 0, 1, 0, "br_over_lu",      0, 0, 0, 0, 1, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, "br_after",        0, 0, 0, 0, 0, 0, 0, 0, 0);
    // freeze for 3 cycles inside a load-use window
    cyc(1, 1, 0, 7, 1, 1, 0, 0, "frz_load",        0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 7, 7, 8, 1, 0, 0, 1, "frz_hold",      0, 0, 1, 1, 0, 0, 1, 0, 0);
    cyc(1, 7, 7, 8, 1, 0, 0, 0, "frz_release_lu",  0, 0, 1, 1, 0, 1, 0, 1, 0);
    cyc(1, 7, 7, 8, 1, 0, 0, 0, "frz_bubble",      0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, "frz_fwd_w",       1, 1, 0, 0, 0, 0, 0, 0, 0);
    // reserved result source behaves as ALU: no stall, forwarded from M
    cyc(1, 1, 2, 12, 1, 3, 0, 0, "rs11_writer",    0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 12, 0, 13, 1, 0, 0, 0, "rs11_use_issue", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, "rs11_fwd_m",      2, 0, 0, 0, 0, 0, 0, 0, 0);

    // let the monitor drain, bounded
    for (int i = 0; i < 4 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
